ex_mem_stage_reg: RTL and testbench

//  Parametrised EX->MEM pipeline register for the 5-stage core, replacing the fixed 64-bit latch.

---
 rtl/ex_mem_stage_reg_pkg.sv | 15 +
 rtl/ex_mem_stage_reg_if.sv | 42 ++++
 rtl/ex_mem_stage_reg_skid_buf.sv | 60 ++++++
 rtl/ex_mem_stage_reg.sv | 46 ++++
 tb/tb_ex_mem_stage_reg.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_reg_pkg.sv
// ex_mem_stage_reg_pkg: shared pipeline defaults and MEM/WB control bit positions.
package ex_mem_stage_reg_pkg;
    localparam int XLEN_DEF       = 64;
    localparam int RADDR_W_DEF    = 5;
    localparam int CTRL_W_DEF     = 4;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_TO_REG = 3;

    // Payload is {br_target, alu, store, instr, rd, ctrl, pc_src}.
    function automatic int payload_w(input int xlen, input int raddr_w, input int ctrl_w);
        return 4 * xlen + raddr_w + ctrl_w + 1;
    endfunction
endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// ex_mem_stage_reg_if: EX->MEM handshake bus; master is the EX/MEM side, slave the stage.
interface ex_mem_stage_reg_if
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_br_target;
    logic [XLEN-1:0]    in_alu_result;
    logic [XLEN-1:0]    in_store_data;
    logic [XLEN-1:0]    in_instr;
    logic [RADDR_W-1:0] in_rd;
    logic [CTRL_W-1:0]  in_ctrl;
    logic               in_branch;
    logic               in_zero;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_br_target;
    logic               out_pc_src;
    logic [XLEN-1:0]    out_mem_addr;
    logic [XLEN-1:0]    out_write_data;
    logic [XLEN-1:0]    out_instr;
    logic [RADDR_W-1:0] out_rd;
    logic [CTRL_W-1:0]  out_ctrl;

    modport master (
        output flush, in_valid, in_br_target, in_alu_result, in_store_data, in_instr,
               in_rd, in_ctrl, in_branch, in_zero, out_ready,
        input  in_ready, out_valid, out_br_target, out_pc_src, out_mem_addr,
               out_write_data, out_instr, out_rd, out_ctrl
    );
    modport slave (
        input  flush, in_valid, in_br_target, in_alu_result, in_store_data, in_instr,
               in_rd, in_ctrl, in_branch, in_zero, out_ready,
        output in_ready, out_valid, out_br_target, out_pc_src, out_mem_addr,
               out_write_data, out_instr, out_rd, out_ctrl
    );
endinterface

// File: rtl/ex_mem_stage_reg_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer (main + skid) with flush.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic         accept, pop;

    // skid_v_q is a flop, so in_ready never depends combinationally on out_ready.
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign pop       = main_v_q & out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (pop && skid_v_q) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end else if (pop || !main_v_q) begin
            main_v_d = accept;
            main_d   = accept ? in_data : main_q;
        end else if (accept) begin
            skid_d   = in_data;
            skid_v_d = 1'b1;
        end
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end
endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register with skid buffer, flush, branch resolve
// and write-enable qualification (no writes for bubbles or to x0).
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF
) (
    input logic               clk,
    input logic               reset,
    ex_mem_stage_reg_if.slave bus
);
    localparam int W = payload_w(XLEN, RADDR_W, CTRL_W);

    logic [CTRL_W-1:0] ctrl_m, ctrl_r;
    logic [W-1:0]      pay_in, pay_out;
    logic              pc_r, out_valid;

    always_comb begin
        ctrl_m = bus.in_ctrl;
        ctrl_m[CTRL_REG_WRITE] = bus.in_ctrl[CTRL_REG_WRITE] & (bus.in_rd != '0);
    end

    assign pay_in = {bus.in_br_target, bus.in_alu_result, bus.in_store_data, bus.in_instr,
                     bus.in_rd, ctrl_m, bus.in_branch & bus.in_zero};
    assign {bus.out_br_target, bus.out_mem_addr, bus.out_write_data, bus.out_instr,
            bus.out_rd, ctrl_r, pc_r} = pay_out;

    // Only control is gated: data outputs may show stale values under a bubble.
    assign bus.out_valid  = out_valid;
    assign bus.out_pc_src = out_valid & pc_r;
    assign bus.out_ctrl   = out_valid ? ctrl_r : '0;

    pipe_skid_buf #(.W(W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (pay_out)
    );
endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: directed + random stimulus against a FIFO-queue reference model.
module tb_ex_mem_stage_reg;
    typedef struct {
        logic [63:0] tgt, alu, st, ins;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        pc;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    ex_mem_stage_reg_if bus ();
    ex_mem_stage_reg dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] tgt, input logic [63:0] alu,
                         input logic [63:0] st, input logic [63:0] ins, input logic [4:0] rd,
                         input logic [3:0] ctrl, input logic br, input logic z);
        bus.in_valid = v;
        bus.in_br_target = tgt;
        bus.in_alu_result = alu;
        bus.in_store_data = st;
        bus.in_instr = ins;
        bus.in_rd = rd;
        bus.in_ctrl = ctrl;
        bus.in_branch = br;
        bus.in_zero = z;
    endtask

    // Check outputs against the queue head, then advance the model across one clock edge.
    task automatic tick(input logic ordy, input logic fl);
        ent_t e;
        logic ready, acc, pop;
        bus.out_ready = ordy;
        bus.flush = fl;
        #1;
        if (!reset) begin
            chk("in_ready", bus.in_ready, q.size() < 2);
            chk("out_valid", bus.out_valid, q.size() > 0);
            if (q.size() == 0) begin
                chk("bubble_ctrl", bus.out_ctrl, 0);
                chk("bubble_pc_src", bus.out_pc_src, 0);
            end else begin
                chk("mem_addr", bus.out_mem_addr, q[0].alu);
                chk("br_target", bus.out_br_target, q[0].tgt);
                chk("write_data", bus.out_write_data, q[0].st);
                chk("instr", bus.out_instr, q[0].ins);
                chk("rd", bus.out_rd, q[0].rd);
                chk("ctrl", bus.out_ctrl, q[0].ctrl);
                chk("pc_src", bus.out_pc_src, q[0].pc);
            end
        end
        if (reset || fl) q.delete();
        else begin
            ready = q.size() < 2;
            acc = bus.in_valid && ready;
            pop = q.size() > 0 && ordy;
            e.tgt = bus.in_br_target;
            e.alu = bus.in_alu_result;
            e.st = bus.in_store_data;
            e.ins = bus.in_instr;
            e.rd = bus.in_rd;
            e.ctrl = (bus.in_rd == 0) ? (bus.in_ctrl & 4'b1110) : bus.in_ctrl;
            e.pc = bus.in_branch & bus.in_zero;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset for two cycles with a valid input present.
        reset = 1'b1;
        drive(1, 64'h5, 64'h6, 64'h7, 64'h8, 5'd3, 4'hF, 1, 1);
        tick(1, 0);
        tick(1, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_ctrl", bus.out_ctrl, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mem_addr", bus.out_mem_addr, 0);
        chk("rst_br_target", bus.out_br_target, 0);
        // Streaming 0x10..0x40.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 64'(i * 16), 64'(i), 64'(i + 100), 5'(i), 4'b0101, 0, 0);
            tick(1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0);
        tick(1, 0);
        // Backpressure: A then B into skid, hold 3 cycles, then drain.
        drive(1, 64'hA, 64'hA0, 64'hA1, 64'hA2, 5'd1, 4'b0011, 0, 0);
        tick(0, 0);
        drive(1, 64'hB, 64'hB0, 64'hB1, 64'hB2, 5'd2, 4'b0100, 0, 0);
        tick(0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_in_ready", bus.in_ready, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        chk("bp_hold_a", bus.out_mem_addr, 64'hA0);
        tick(1, 0);
        chk("bp_then_b", bus.out_mem_addr, 64'hB0);
        tick(1, 0);
        tick(1, 0);
        // Flush with main and skid full and C presented.
        drive(1, 64'h1, 64'h11, 0, 0, 5'd4, 4'b0001, 0, 0);
        tick(0, 0);
        drive(1, 64'h2, 64'h22, 0, 0, 5'd5, 4'b0001, 0, 0);
        tick(0, 0);
        drive(1, 64'h3, 64'hC0, 0, 0, 5'd6, 4'b0001, 0, 0);
        tick(0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        tick(1, 0);
        tick(1, 0);
        // Branch taken/not taken and x0 masking.
        drive(1, 64'h1000, 64'h40, 0, 0, 5'd7, 4'b0000, 1, 1);
        tick(1, 0);
        drive(1, 64'h2000, 64'h44, 0, 0, 5'd7, 4'b0000, 1, 0);
        chk("br_taken_pc_src", bus.out_pc_src, 1);
        chk("br_taken_target", bus.out_br_target, 64'h1000);
        tick(1, 0);
        drive(1, 0, 64'h48, 0, 0, 5'd0, 4'b1001, 0, 0);
        chk("br_not_taken", bus.out_pc_src, 0);
        tick(1, 0);
        drive(0, 64'h9, 64'h9, 0, 0, 5'd9, 4'b1111, 1, 1);
        chk("x0_ctrl", bus.out_ctrl, 4'b1000);
        tick(1, 0);
        // Bubble gating with control bits all set on the idle input.
        tick(1, 0);
        chk("bubble_ctrl_dir", bus.out_ctrl, 0);
        // Random traffic with flushes and occasional reset.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom));
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
